y86_bus_tracer: RTL and testbench
=================================

Name: y86_bus_tracer

Overview:
- Passive trace and statistics unit downstream of the y86 sequential core.
- Snoops the core's memory bus (bus_A, bus_in, bus_out, bus_RE, bus_WE), classifies each transfer as instruction fetch, data load or data store, and timestamps it.
- Buffers the records in a FIFO that is drained over a valid/ready port.
- Keeps per-kind transfer counters and a dropped-record counter.
- Never drives the core's bus.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- TS_W, 16, timestamp width in bits.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high; same net as the core reset
- en  in  1  capture enable; phase tracking runs regardless
- clr  in  1  synchronous clear of FIFO, counters and sticky flags
- bus_A  in  32  core bus address
- bus_in  in  32  read data returned to the core
- bus_out  in  32  core write data
- bus_RE  in  1  core read enable
- bus_WE  in  1  core write enable
- trc_valid  out  1  FIFO head valid
- trc_ready  in  1  consumer accepts head
- trc_data  out  66+TS_W  {kind[1:0], ts[TS_W-1:0], addr[31:0], data[31:0]}
- n_fetch  out  32  fetch count
- n_load  out  32  load count
- n_store  out  32  store count
- n_drop  out  DROP_W  records dropped because the FIFO was full
- overflow  out  1  sticky, set on the first drop
- sync_err  out  1  sticky, set on a bus strobe in an illegal phase
- level  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, immediate): phase=0, ts=0, FIFO empty, all counters 0, overflow=0, sync_err=0, trc_valid=0, trc_data=0.
- Phase tracker:
  - Mod-5 counter advancing every cycle after reset, mirroring the core's one-hot sequencer.
  - Phase 0 = fetch, 3 = memory. The first cycle after reset deassertion is phase 0.
- Classification, evaluated each cycle when en=1:
  - phase 0 and bus_RE -> kind 00 (fetch), data=bus_in.
  - phase 3 and bus_RE and !bus_WE -> kind 01 (load), data=bus_in.
  - phase 3 and bus_WE -> kind 10 (store), data=bus_out.
  - addr=bus_A; ts=value of the timestamp counter in that cycle.
  - kind 11 is reserved and never produced.
- Illegal strobes:
  - bus_RE or bus_WE in phases 1, 2 or 4, or bus_WE in phase 0, or bus_RE and bus_WE together: set sync_err and push no record.
  - The affected counter is not incremented.
  - sync_err is set even when en=0.
- Counters:
  - The matching n_* increments in the cycle after the event, wrapping at 2^32.
  - Counters increment whether or not the record fits in the FIFO.
- FIFO:
  - A push is a legal classified event with en=1. A pop is trc_valid && trc_ready.
  - Latency: a record pushed in cycle N is visible at the head in cycle N+1.
  - trc_data holds its value while trc_valid && !trc_ready.
  - trc_data is don't-care when trc_valid=0; hold the last value.
  - Full and push without pop: drop the record, n_drop saturates at all-ones, overflow set.
  - Full with simultaneous push and pop: both happen, nothing is dropped, level unchanged.
  - Empty with push: the pop is not possible that cycle, so there is no bypass.
  - Pointers wrap modulo DEPTH; level ranges 0..DEPTH.
- Timestamp: free-running, increments every cycle and wraps at 2^TS_W. clr does not reset it.
- clr:
  - Next edge: FIFO emptied, n_* and n_drop zeroed, overflow and sync_err cleared.
  - An event in the same cycle as clr is discarded and not counted.
  - Phase is not affected.
- Reset mid-operation: all state is lost immediately; the FIFO contents are not recoverable. Phase restarts at 0 together with the core.

Test Plan:
- Reset release, core fetches at IP=0 with bus_in=0x0000C001 -> next cycle trc_valid=1, kind=00, addr=0, data=0x0000C001, ts=0, n_fetch=1.
- Core executes a store (MAR=0x40, MDRw=0xDEADBEEF, bus_WE in phase 3), then a load from 0x40 with bus_in=0xDEADBEEF -> records kind 10 and kind 01, both with addr 0x40, and the load's ts is 5 greater than the store's; n_store=1, n_load=1.
- Hold trc_ready=0 for DEPTH+3 legal events -> level=16, n_drop=3, overflow=1, and the counters count all events.
- With the FIFO full, assert trc_ready=1 in the same cycle as a fetch -> no drop, level stays 16, the head advances by one.
- Force bus_RE=1 in phase 2 -> sync_err=1, no record pushed, counters unchanged; pulse clr -> sync_err=0.
- Assert rst asynchronously mid-clock with 5 records queued -> trc_valid=0, level=0 and counters 0 before the next edge; the first record after release has ts=0.

Source files
------------

// File: rtl/y86_bus_tracer.sv
// ---------------------------------------------------------------------------
// y86_bus_tracer
//
// Passive trace and statistics unit that sits beside the y86 sequential core.
// It snoops the core memory bus, classifies each transfer as an instruction
// fetch, a data load or a data store, timestamps it and queues the record in
// a FIFO drained over a valid/ready port. It also keeps per-kind transfer
// counters, a saturating dropped-record counter and two sticky error flags.
// The core bus is only observed, never driven.
//
// Parameters:
//   DEPTH   FIFO entries (power of two, >= 2)
//   TS_W    timestamp width
//   DROP_W  width of the saturating drop counter
//
// Ports:
//   clk, rst          core clock, async active-high reset (shared with core)
//   en                capture enable (phase tracking always runs)
//   clr               synchronous clear of FIFO, counters and sticky flags
//   bus_A/in/out      core address, read data, write data
//   bus_RE/bus_WE     core read / write strobes
//   trc_valid/ready   trace output handshake
//   trc_data          {kind[1:0], ts[TS_W-1:0], addr[31:0], data[31:0]}
//   n_fetch/load/store  per-kind transfer counters (wrapping)
//   n_drop            records lost to a full FIFO (saturating)
//   overflow          sticky, set on the first drop
//   sync_err          sticky, set on a strobe in an illegal phase
//   level             FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module y86_bus_tracer #(
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int DROP_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr,
    input  logic [31:0]               bus_A,
    input  logic [31:0]               bus_in,
    input  logic [31:0]               bus_out,
    input  logic                      bus_RE,
    input  logic                      bus_WE,
    output logic                      trc_valid,
    input  logic                      trc_ready,
    output logic [65+TS_W:0]          trc_data,
    output logic [31:0]               n_fetch,
    output logic [31:0]               n_load,
    output logic [31:0]               n_store,
    output logic [DROP_W-1:0]         n_drop,
    output logic                      overflow,
    output logic                      sync_err,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = 66 + TS_W;

    // Phases mirror the core's one-hot sequencer: only FETCH and MEM may
    // legally carry bus strobes.
    typedef enum logic [2:0] {
        PH_FETCH  = 3'd0,
        PH_DECODE = 3'd1,
        PH_EXEC   = 3'd2,
        PH_MEM    = 3'd3,
        PH_WB     = 3'd4
    } phase_t;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'b00,
        KIND_LOAD  = 2'b01,
        KIND_STORE = 2'b10,
        KIND_RSVD  = 2'b11
    } kind_t;

    phase_t              phase, phase_next;
    logic [TS_W-1:0]     ts;

    logic [REC_W-1:0]    mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr, rd_ptr_next;
    logic [AW:0]         count, count_next;
    logic [REC_W-1:0]    data_q;

    logic                illegal, is_event;
    kind_t               kind;
    logic [31:0]         rec_data;
    logic [REC_W-1:0]    rec;
    logic                push_req, push_do, pop, full, drop;

    // Phase sequencer: free-running mod-5, restarts at FETCH with the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase <= PH_FETCH;
        else     phase <= phase_next;
    end

    always_comb begin
        phase_next = PH_FETCH;
        case (phase)
            PH_FETCH:  phase_next = PH_DECODE;
            PH_DECODE: phase_next = PH_EXEC;
            PH_EXEC:   phase_next = PH_MEM;
            PH_MEM:    phase_next = PH_WB;
            default:   phase_next = PH_FETCH;
        endcase
    end

    // Free-running timestamp; clr deliberately leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts <= '0;
        else     ts <= ts + 1'b1;
    end

    // Classification. Simultaneous RE and WE is illegal in every phase,
    // so it is tested before the per-phase rules.
    always_comb begin
        illegal  = 1'b0;
        is_event = 1'b0;
        kind     = KIND_FETCH;
        rec_data = bus_in;
        if (bus_RE && bus_WE) begin
            illegal = 1'b1;
        end else begin
            case (phase)
                PH_FETCH: begin
                    if (bus_WE)      illegal  = 1'b1;
                    else if (bus_RE) is_event = 1'b1;
                end
                PH_MEM: begin
                    if (bus_WE) begin
                        is_event = 1'b1;
                        kind     = KIND_STORE;
                        rec_data = bus_out;
                    end else if (bus_RE) begin
                        is_event = 1'b1;
                        kind     = KIND_LOAD;
                    end
                end
                default: begin
                    if (bus_RE || bus_WE) illegal = 1'b1;
                end
            endcase
        end
    end

    assign rec       = {kind, ts, bus_A, rec_data};
    assign full      = (count == DEPTH[AW:0]);
    assign trc_valid = (count != '0);
    assign push_req  = en && !clr && is_event;
    assign pop       = trc_valid && trc_ready && !clr;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_do   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    always_comb begin
        rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;
        count_next  = count;
        case ({push_do, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage array; contents are only observed through data_q.
    always_ff @(posedge clk) begin
        if (push_do) mem[wr_ptr] <= rec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_do) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
        end
    end

    // Registered head. When the FIFO ends the cycle with exactly one entry
    // that was just pushed, the new record is the head and is not yet in the
    // array, so it is taken straight from the classifier. When the FIFO goes
    // empty the last head is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (!clr && count_next != '0) begin
            if (push_do && count_next == {{AW{1'b0}}, 1'b1}) data_q <= rec;
            else                                             data_q <= mem[rd_ptr_next];
        end
    end

    assign trc_data = data_q;
    assign level    = count;

    // Statistics and sticky flags. Counters track accepted events even when
    // the record itself is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_fetch  <= '0;
            n_load   <= '0;
            n_store  <= '0;
            n_drop   <= '0;
            overflow <= 1'b0;
            sync_err <= 1'b0;
        end else if (clr) begin
            n_fetch  <= '0;
            n_load   <= '0;
            n_store  <= '0;
            n_drop   <= '0;
            overflow <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            if (push_req) begin
                case (kind)
                    KIND_FETCH: n_fetch <= n_fetch + 1'b1;
                    KIND_LOAD:  n_load  <= n_load + 1'b1;
                    KIND_STORE: n_store <= n_store + 1'b1;
                    default:    ;
                endcase
            end
            if (drop) begin
                overflow <= 1'b1;
                if (n_drop != '1) n_drop <= n_drop + 1'b1;
            end
            if (illegal) sync_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_y86_bus_tracer.sv
// ---------------------------------------------------------------------------
// tb_y86_bus_tracer
//
// Directed bench for y86_bus_tracer. A small reference model tracks phase,
// timestamp, counters and flags; expected trace records are pushed to a
// scoreboard queue when the stimulus produces them and popped whenever the
// DUT hands a record over the valid/ready port.
// ---------------------------------------------------------------------------
module tb_y86_bus_tracer;

    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;
    localparam int DROP_W = 8;
    localparam int REC_W  = 66 + TS_W;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              en;
    logic              clr;
    logic [31:0]       bus_A;
    logic [31:0]       bus_in;
    logic [31:0]       bus_out;
    logic              bus_RE;
    logic              bus_WE;
    logic              trc_valid;
    logic              trc_ready;
    logic [REC_W-1:0]  trc_data;
    logic [31:0]       n_fetch;
    logic [31:0]       n_load;
    logic [31:0]       n_store;
    logic [DROP_W-1:0] n_drop;
    logic              overflow;
    logic              sync_err;
    logic [LW-1:0]     level;

    y86_bus_tracer #(
        .DEPTH  (DEPTH),
        .TS_W   (TS_W),
        .DROP_W (DROP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .bus_A     (bus_A),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_RE    (bus_RE),
        .bus_WE    (bus_WE),
        .trc_valid (trc_valid),
        .trc_ready (trc_ready),
        .trc_data  (trc_data),
        .n_fetch   (n_fetch),
        .n_load    (n_load),
        .n_store   (n_store),
        .n_drop    (n_drop),
        .overflow  (overflow),
        .sync_err  (sync_err),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [REC_W-1:0] sb[$];
    int               m_phase;
    logic [TS_W-1:0]  m_ts;
    int               m_count;
    logic [31:0]      m_fetch, m_load, m_store;
    int               m_drop;
    logic             m_ovf, m_serr;

    function automatic logic [REC_W-1:0] mkRec(input logic [1:0] k, input logic [TS_W-1:0] t,
                                               input logic [31:0] a, input logic [31:0] d);
        return {k, t, a, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkState();
        checkOutput("trc_valid", trc_valid, m_count > 0);
        checkOutput("level", level, m_count);
        checkOutput("n_fetch", n_fetch, m_fetch);
        checkOutput("n_load", n_load, m_load);
        checkOutput("n_store", n_store, m_store);
        checkOutput("n_drop", n_drop, m_drop);
        checkOutput("overflow", overflow, m_ovf);
        checkOutput("sync_err", sync_err, m_serr);
        if (m_count > 0) checkOutput("trc_head", trc_data, sb[0]);
    endtask

    task automatic modelReset();
        m_phase = 0;
        m_ts    = '0;
        m_count = 0;
        m_fetch = '0;
        m_load  = '0;
        m_store = '0;
        m_drop  = 0;
        m_ovf   = 1'b0;
        m_serr  = 1'b0;
        sb.delete();
    endtask

    // One core clock cycle: drive the bus, compare any record handed over,
    // advance the model, then check the registered outputs after the edge.
    task automatic applyStimulus(input logic re, input logic we, input logic [31:0] a,
                                 input logic [31:0] din, input logic [31:0] dout,
                                 input logic rdy, input logic en_v, input logic clr_v);
        logic             bad, legal, pop;
        logic [1:0]       k;
        logic [31:0]      d;
        logic [REC_W-1:0] exp;
        bus_RE    = re;
        bus_WE    = we;
        bus_A     = a;
        bus_in    = din;
        bus_out   = dout;
        trc_ready = rdy;
        en        = en_v;
        clr       = clr_v;
        #4;
        bad   = (re && we) || ((re || we) && (m_phase == 1 || m_phase == 2 || m_phase == 4))
                || (we && m_phase == 0);
        legal = !bad && ((m_phase == 0 && re) || (m_phase == 3 && (re || we)));
        k     = (m_phase == 0) ? 2'b00 : (we ? 2'b10 : 2'b01);
        d     = we ? dout : din;
        pop   = (m_count > 0) && rdy && !clr_v;
        checkOutput("trc_valid_pre", trc_valid, m_count > 0);
        if (pop) begin
            exp = sb.pop_front();
            checkOutput("trc_data_pop", trc_data, exp);
        end
        if (clr_v) begin
            sb.delete();
            m_count = 0;
            m_fetch = '0;
            m_load  = '0;
            m_store = '0;
            m_drop  = 0;
            m_ovf   = 1'b0;
            m_serr  = 1'b0;
        end else begin
            if (bad) m_serr = 1'b1;
            if (pop) m_count--;
            if (legal && en_v) begin
                case (k)
                    2'b00:   m_fetch++;
                    2'b01:   m_load++;
                    default: m_store++;
                endcase
                if (m_count < DEPTH) begin
                    sb.push_back(mkRec(k, m_ts, a, d));
                    m_count++;
                end else begin
                    if (m_drop < (1 << DROP_W) - 1) m_drop++;
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_phase = (m_phase + 1) % 5;
        m_ts    = m_ts + 1'b1;
        checkState();
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, rdy, 1'b1, 1'b0);
    endtask

    initial begin
        int evs;
        logic [REC_W-1:0] nxt;
        rst       = 1'b1;
        en        = 1'b1;
        clr       = 1'b0;
        bus_A     = '0;
        bus_in    = '0;
        bus_out   = '0;
        bus_RE    = 1'b0;
        bus_WE    = 1'b0;
        trc_ready = 1'b0;
        modelReset();
        #1;
        checkState();
        checkOutput("reset_trc_data", trc_data, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("[TB] reset released");

        // First fetch at IP=0
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0000C001, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("first_fetch_rec", trc_data, {2'b00, 16'h0000, 32'h0, 32'h0000C001});
        checkOutput("first_n_fetch", n_fetch, 32'd1);

        // Store to 0x40, then fetch and load back from 0x40
        idle(1'b0);
        idle(1'b0);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        applyStimulus(1'b1, 1'b0, 32'h1, 32'h00001234, 32'h0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b0);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        checkOutput("n_store_one", n_store, 32'd1);
        checkOutput("n_load_one", n_load, 32'd1);
        idle(1'b1);
        checkOutput("store_rec", trc_data, {2'b10, 16'd3, 32'h40, 32'hDEADBEEF});
        idle(1'b1);
        idle(1'b1);
        checkOutput("load_rec", trc_data, {2'b01, 16'd8, 32'h40, 32'hDEADBEEF});
        idle(1'b1);
        checkOutput("drained_level", level, 0);

        // Fill past capacity with ready held low
        evs = 0;
        for (int g = 0; g < 200 && evs < DEPTH + 3; g++) begin
            if (m_phase == 0 || m_phase == 3) begin
                applyStimulus(1'b1, 1'b0, 32'h1000 + evs, $urandom, 32'h0, 1'b0, 1'b1, 1'b0);
                evs++;
            end else begin
                idle(1'b0);
            end
        end
        checkOutput("fill_level", level, DEPTH);
        checkOutput("fill_drop", n_drop, 3);
        checkOutput("fill_overflow", overflow, 1'b1);

        // Full FIFO: fetch and pop in the same cycle
        for (int i = 0; i < 5 && m_phase != 0; i++) idle(1'b0);
        nxt = sb[1];
        applyStimulus(1'b1, 1'b0, 32'h2000, 32'hCAFE0001, 32'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("full_pp_level", level, DEPTH);
        checkOutput("full_pp_drop", n_drop, 3);
        checkOutput("full_pp_head", trc_data, nxt);

        // Drain everything through the scoreboard
        for (int i = 0; i < DEPTH + 4 && m_count > 0; i++) idle(1'b1);
        checkOutput("drain_all_level", level, 0);

        // Illegal read strobe in phase 2
        for (int i = 0; i < 5 && m_phase != 2; i++) idle(1'b0);
        applyStimulus(1'b1, 1'b0, 32'h200, 32'h77, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("serr_set", sync_err, 1'b1);
        checkOutput("serr_no_push", level, 0);
        checkOutput("serr_n_store", n_store, 32'd1);

        // clr pulse
        idle(1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_serr", sync_err, 1'b0);
        checkOutput("clr_n_fetch", n_fetch, 32'd0);
        checkOutput("clr_n_drop", n_drop, 0);
        checkOutput("clr_overflow", overflow, 1'b0);

        // Event coincident with clr is discarded
        for (int i = 0; i < 5 && m_phase != 0; i++) idle(1'b0);
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h55, 32'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_evt_n_fetch", n_fetch, 32'd0);
        checkOutput("clr_evt_level", level, 0);

        // en=0: no capture, but illegal strobe still flags
        for (int i = 0; i < 5 && m_phase != 0; i++) idle(1'b0);
        applyStimulus(1'b1, 1'b0, 32'h310, 32'h66, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("en0_level", level, 0);
        applyStimulus(1'b0, 1'b1, 32'h320, 32'h0, 32'h99, 1'b0, 1'b0, 1'b0);
        checkOutput("en0_serr", sync_err, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

        // Queue five records, then reset asynchronously between edges
        for (int g = 0; g < 60 && m_count < 5; g++) begin
            if (m_phase == 0 || m_phase == 3)
                applyStimulus(1'b1, 1'b0, 32'h400 + g, $urandom, 32'h0, 1'b0, 1'b1, 1'b0);
            else
                idle(1'b0);
        end
        checkOutput("queued_five", level, 5);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkState();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h500, 32'h0000ABCD, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("post_reset_rec", trc_data, {2'b00, 16'h0000, 32'h500, 32'h0000ABCD});
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
